// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle logic/arithmetic,
// iterative 1-bit-per-cycle shifter, one operation in flight at a time.
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_sel,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] work;
   logic [SHW-1:0]  cnt;
   logic [1:0]      sh_op;     // alu_sel[1:0] of the latched shift: 01 SLL, 10 SRL, 11 SRA

   logic [XLEN-1:0] calc_res;
   logic            calc_ill;
   logic            is_shift;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] work_nxt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign shamt     = op_b[SHW-1:0];
   assign is_shift  = (alu_sel == 4'b0101) || (alu_sel == 4'b0110) || (alu_sel == 4'b0111);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      calc_res = '0;
      calc_ill = 1'b0;
      case (alu_sel)
         4'b0000: calc_res = op_a + op_b;
         4'b0001: calc_res = op_a - op_b;
         4'b0010: calc_res = op_a & op_b;
         4'b0011: calc_res = op_a | op_b;
         4'b0100: calc_res = op_a ^ op_b;
         4'b0101, 4'b0110, 4'b0111: calc_res = op_a;   // zero-amount shift
         4'b1000: calc_res = XLEN'($signed(op_a) < $signed(op_b));
         4'b1001: calc_res = XLEN'(op_a < op_b);
         default: calc_ill = 1'b1;
      endcase
   end

   always_comb begin
      case (sh_op)
         2'b01:   work_nxt = work << 1;
         2'b10:   work_nxt = work >> 1;
         default: work_nxt = {work[XLEN-1], work[XLEN-1:1]};
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         result  <= '0;
         zero    <= 1'b1;
         illegal <= 1'b0;
         work    <= '0;
         cnt     <= '0;
         sh_op   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && (shamt != '0)) begin
                     work  <= op_a;
                     cnt   <= shamt;
                     sh_op <= alu_sel[1:0];
                     state <= SHIFT;
                  end else begin
                     result  <= calc_res;
                     zero    <= (calc_res == '0);
                     illegal <= calc_ill;
                     state   <= DONE;
                  end
               end
            end
            SHIFT: begin
               work <= work_nxt;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  result  <= work_nxt;
                  zero    <= (work_nxt == '0);
                  illegal <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors with hand-computed results
// plus a cycle-level behavioural model compared against the DUT on every cycle.
module tb_alu_exec_unit;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_sel;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int n_checks = 0;
   int n_errors = 0;

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_sel   (alu_sel),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour computed directly from the operation definitions.
   function automatic logic [31:0] model_res(input logic [3:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
      case (sel)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] sel, input logic [31:0] b);
      if (sel >= 4'd5 && sel <= 4'd7) return 1 + int'(b[4:0]);
      return 1;
   endfunction

   // Cycle-level model: ready/valid flags, a countdown for pending shifts, held outputs.
   logic        m_ready, m_valid, m_ill, chk_en;
   logic [31:0] m_res, p_res;
   int          m_wait;

   initial chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ready <= 1'b1;
         m_valid <= 1'b0;
         m_res   <= 32'd0;
         m_ill   <= 1'b0;
         m_wait  <= 0;
         chk_en  <= 1'b1;
      end else if (m_ready && in_valid) begin
         m_ready <= 1'b0;
         if (model_lat(alu_sel, op_b) == 1) begin
            m_valid <= 1'b1;
            m_res   <= model_res(alu_sel, op_a, op_b);
            m_ill   <= (alu_sel >= 4'b1010);
         end else begin
            m_wait <= model_lat(alu_sel, op_b) - 1;
            p_res  <= model_res(alu_sel, op_a, op_b);
         end
      end else if (m_wait != 0) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) begin
            m_valid <= 1'b1;
            m_res   <= p_res;
            m_ill   <= 1'b0;
         end
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_in_ready", 32'(in_ready), 32'(m_ready));
         check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            check("cmp_result", result, m_res);
            check("cmp_zero", 32'(zero), 32'(m_res == 32'd0));
            check("cmp_illegal", 32'(illegal), 32'(m_ill));
         end
      end
   end

   // Issue one op, measure latency, optionally hold backpressure, then hand-shake it out.
   task automatic do_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                        input logic exp_ill, input int hold);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      alu_sel   = sel;
      op_a      = a;
      op_b      = b;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      alu_sel  = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_result"}, result, exp_r);
      check({name, "_zero"}, 32'(zero), 32'(exp_r == 32'd0));
      check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         op_a     = $urandom;
         @(negedge clk);
         check({name, "_hold_result"}, result, exp_r);
         check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
      check({name, "_post_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_sel   = 4'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_result", result, 32'd0);
      check("reset_zero", 32'(zero), 32'd1);
      check("reset_illegal", 32'(illegal), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;

      do_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1,  1'b0, 0);
      do_op("sub",      4'b0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1,  1'b0, 0);
      do_op("slt",      4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0, 0);
      do_op("sltu",     4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1,  1'b0, 0);
      do_op("slt_neg",  4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1,  1'b0, 0);
      do_op("and",      4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1,  1'b0, 0);
      do_op("or",       4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1,  1'b0, 0);
      do_op("xor_bp",   4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1,  1'b0, 10);
      do_op("sll4",     4'b0101, 32'h8000_0001, 32'd4,         32'h0000_0010, 5,  1'b0, 0);
      do_op("srl31",    4'b0110, 32'h8000_0001, 32'd31,        32'h0000_0001, 32, 1'b0, 0);
      do_op("sra31",    4'b0111, 32'h8000_0001, 32'd31,        32'hFFFF_FFFF, 32, 1'b0, 0);
      do_op("sra0",     4'b0111, 32'h8000_0001, 32'd0,         32'h8000_0001, 1,  1'b0, 0);
      do_op("sra32",    4'b0111, 32'h8000_0001, 32'd32,        32'h8000_0001, 1,  1'b0, 0);
      do_op("illegal",  4'b1100, 32'd5,         32'd7,         32'h0000_0000, 1,  1'b1, 3);
      do_op("ill_clr",  4'b0000, 32'd1,         32'd1,         32'h0000_0002, 1,  1'b0, 0);

      // Reset during a long shift: the op is dropped and the unit is idle afterwards.
      @(negedge clk);
      in_valid = 1'b1;
      alu_sel  = 4'b0101;
      op_a     = 32'h8000_0001;
      op_b     = 32'd20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midshift_out_valid", 32'(out_valid), 32'd0);
      check("midshift_result", result, 32'd0);
      check("midshift_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      do_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_sel code produced by ALU control, plus two operands.
- Returns the result over a valid/ready handshake.
- Logic and arithmetic ops complete in 1 cycle; shifts use an iterative 1-bit-per-cycle shifter to save area.
- Sits between decode/ALU control and writeback; one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width; must be a power of two >= 8.
- SHW, $clog2(XLEN) (derived, localparam), shift-amount width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- alu_sel  input  4  operation code.
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B; shift amount = op_b[SHW-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.
- illegal  output  1  alu_sel was an undefined code.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; result=0; zero=1; illegal=0; out_valid=0; in_ready=1 the cycle after.
  - Reset overrides any in-flight operation, including mid-shift; that operation is discarded with no output.
- alu_sel codes:
  - 0000 ADD: a+b, mod 2^XLEN.
  - 0001 SUB: a-b, mod 2^XLEN.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL.
  - 0110 SRL: zero fill.
  - 0111 SRA: sign fill from a[XLEN-1].
  - 1000 SLT: signed a<b gives 1, else 0; zero-extended.
  - 1001 SLTU: unsigned compare, same result format.
  - 1010-1111: result=0, illegal=1, latency 1.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE), purely a function of state.
  - out_valid = (state==DONE).
- IDLE, on in_valid&&in_ready at edge N:
  - Non-shift op: result register loads the computed value; illegal is set for codes 1010-1111 and cleared otherwise; go to DONE. out_valid rises in cycle N+1 (latency 1).
  - Shift op with shamt==0: result=op_a; go to DONE; latency 1.
  - Shift op with shamt=k>0: working register=op_a, counter=k, op latched; go to SHIFT.
- SHIFT:
  - Each edge shifts the working register by 1 in the latched direction/fill and decrements the counter.
  - The edge on which the counter goes 1→0 moves to DONE.
  - Total latency = 1+k cycles (e.g. 32 for k=31 at XLEN=32).
  - in_valid is ignored in this state.
- DONE:
  - result, zero and illegal are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_valid&&out_ready at an edge: go to IDLE, so in_ready=1 in the next cycle.
  - There is no same-cycle accept in DONE; minimum request spacing is 2 cycles.
- Operands and alu_sel are sampled only on the accepting edge. Later changes do not affect an in-flight operation.
- zero is registered with result; it is valid whenever out_valid=1 and holds its last value otherwise.
- Overflow and carry are not reported; ADD/SUB wrap.
- Only op_b[SHW-1:0] is used for shifts; upper bits are ignored (b=32 at XLEN=32 means a shift of 0).
- in_valid may drop before acceptance without side effects.
- No X on any output after reset.

Test Plan:
- Reset then ADD:
  - Stimulus: rst_n low 2 cycles; sel=0000, a=0xFFFFFFFF, b=1.
  - Required: out_valid exactly 1 cycle after accept; result=0x00000000; zero=1; illegal=0.
- SUB/SLT/SLTU with a=0x00000001, b=0xFFFFFFFF:
  - SUB gives 0x00000002.
  - SLT gives 0 (1 > -1).
  - SLTU gives 1.
  - AND/OR/XOR with a=0xF0F0F0F0, b=0x0FF00FF0 give 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- Shifts with a=0x80000001:
  - SLL b=4 gives 0x00000010, latency 5.
  - SRL b=31 gives 0x00000001, latency 32.
  - SRA b=31 gives 0xFFFFFFFF.
  - SRA b=0 or b=32 gives 0x80000001, latency 1.
  - in_ready=0 throughout each shift.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; toggle op_a/in_valid meanwhile.
  - Required: result/zero stable, in_ready=0, no new accept; one cycle after the out_ready handshake, in_ready=1.
- Illegal code: sel=1100, a=5, b=7 → result=0, zero=1, illegal=1, latency 1; the next legal op clears illegal.
- Reset mid-shift:
  - Stimulus: SLL b=20; assert rst_n=0 at the 6th SHIFT cycle.
  - Required: the next cycle has out_valid=0, result=0, in_ready=1; a subsequent ADD 2+3 gives 5 with latency 1.
